// File: rtl/sr_instr_encoder.sv
// RV32 instruction encoder: packs field-level requests into 32-bit words with a
// sequential word address; out-of-range immediates are dropped and counted.
module sr_instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt,
    input  logic [6:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_f3,
    input  logic [6:0]        req_f7,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_err_pulse;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_fire;
    logic              w_legal;
    logic [31:0]       w_word;
    logic              w_ext11;
    logic              w_ext12;
    logic              w_ext20;

    // Immediate fits when every bit above the field's sign bit matches it.
    assign w_ext11 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign w_ext12 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    assign w_ext20 = (&req_imm[31:20]) | ~(|req_imm[31:20]);

    always_comb begin
        w_legal = 1'b0;
        w_word  = 32'd0;
        case (req_fmt)
            FMT_R: begin
                w_legal = 1'b1;
                w_word  = {req_f7, req_rs2, req_rs1, req_f3, req_rd, req_op};
            end
            FMT_I: begin
                w_legal = w_ext11;
                w_word  = {req_imm[11:0], req_rs1, req_f3, req_rd, req_op};
            end
            FMT_B: begin
                w_legal = w_ext12 & ~req_imm[0];
                w_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                           req_imm[4:1], req_imm[11], req_op};
            end
            FMT_U: begin
                w_legal = ~(|req_imm[11:0]);
                w_word  = {req_imm[31:12], req_rd, req_op};
            end
            FMT_J: begin
                w_legal = w_ext20 & ~req_imm[0];
                w_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                           req_rd, req_op};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = 32'd0;
            end
        endcase
    end

    assign req_ready = !r_valid || out_ready;
    assign w_fire    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_instr     <= 32'd0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else if (clear) begin
            // A same-cycle request is swallowed here: handshake completes, nothing emitted.
            r_valid     <= 1'b0;
            r_cnt       <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_fire && !w_legal;
            if (w_fire && w_legal) begin
                r_valid <= 1'b1;
                r_instr <= w_word;
                r_addr  <= r_cnt;
                r_cnt   <= r_cnt + ADDR_W'(1);
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_fire && !w_legal && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_sr_instr_encoder.sv
// Scoreboard bench for sr_instr_encoder: a default-width instance plus a
// 2-bit address / 2-bit error-count instance share the same stimulus.
module tb_sr_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_fmt = '0;
    logic [6:0]  req_op = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [2:0]  req_f3 = '0;
    logic [6:0]  req_f7 = '0;
    logic [31:0] req_imm = '0;
    logic        out_ready = 1'b0;

    logic        req_ready, out_valid, err_pulse;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic [7:0]  err_count;

    logic        s_req_ready, s_out_valid, s_err_pulse;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;
    logic [1:0]  s_err_count;

    sr_instr_encoder #(.ADDR_W(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_f3(req_f3), .req_f7(req_f7), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
    );

    sr_instr_encoder #(.ADDR_W(2), .ERR_W(2)) dut_s (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_f3(req_f3), .req_f7(req_f7), .req_imm(req_imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_addr(s_out_addr), .err_pulse(s_err_pulse), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_addr = 0;
    int          m_err = 0;

    function automatic bit model_legal(input logic [2:0] fmt, input logic [31:0] imm);
        int s;
        s = signed'(imm);
        case (fmt)
            3'd0: return 1'b1;
            3'd1: return (s >= -2048) && (s <= 2047);
            3'd2: return (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
            3'd3: return (imm & 32'hFFF) == 0;
            3'd4: return (s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_pack(input logic [2:0] fmt, input logic [6:0] op,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'(op);
        case (fmt)
            3'd0: w |= (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            3'd1: w |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            3'd2: w |= (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (32'(rs2) << 20)
                     | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
            3'd3: w |= (imm & 32'hFFFFF000) | (32'(rd) << 7);
            default: w |= (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
                     | (((imm >> 12) & 255) << 12) | (32'(rd) << 7);
        endcase
        return w;
    endfunction

    // Consumer side: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got instr=%08h addr=%0d, expected none", out_instr, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_instr !== e.instr || out_addr !== e.addr) begin
                    errors++;
                    $display("FAIL sb_word: got %08h@%0d, expected %08h@%0d", out_instr, out_addr, e.instr, e.addr);
                end
                checks++;
                if (s_out_valid !== 1'b1 || s_out_instr !== e.instr || s_out_addr !== e.addr[1:0]) begin
                    errors++;
                    $display("FAIL sb_small: got v=%0b %08h@%0d, expected %08h@%0d", s_out_valid, s_out_instr, s_out_addr, e.instr, e.addr[1:0]);
                end
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] imm);
        int   n;
        bit   legal;
        exp_t e;
        req_fmt = fmt; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_f3 = f3; req_f7 = f7; req_imm = imm; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_timeout: req_ready=%0b, expected 1 within 50 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        legal = model_legal(fmt, imm);
        e.instr = model_pack(fmt, op, rd, rs1, rs2, f3, f7, imm);
        e.addr  = m_addr;
        @(posedge clk);
        if (legal) begin
            sb.push_back(e);
            m_addr = m_addr + 8'd1;
        end else begin
            m_err++;
        end
        #1;
        req_valid = 1'b0;
        checks++;
        if (err_pulse !== !legal || s_err_pulse !== !legal) begin
            errors++;
            $display("FAIL err_pulse: got %0b/%0b, expected %0b", err_pulse, s_err_pulse, !legal);
        end
        checks++;
        if (err_count !== 8'(m_err) || s_err_count !== 2'((m_err > 3) ? 3 : m_err)) begin
            errors++;
            $display("FAIL err_count: got %0d/%0d, expected %0d", err_count, s_err_count, m_err);
        end
        if (legal) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== e.instr || out_addr !== e.addr) begin
                errors++;
                $display("FAIL latency: got v=%0b %08h@%0d, expected %08h@%0d", out_valid, out_instr, out_addr, e.instr, e.addr);
            end
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] exp);
        checks++;
        if (out_instr !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, out_instr, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || out_instr !== 0 || out_addr !== 0 || err_pulse !== 0 ||
            err_count !== 0 || req_ready !== 1 || s_out_valid !== 0 || s_err_count !== 0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b i=%08h a=%0d p=%0b c=%0d rdy=%0b, expected zeros rdy=1",
                     out_valid, out_instr, out_addr, err_pulse, err_count, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check_word("r_add", 32'h002081B3);
        checks++;
        if (out_addr !== 8'd0) begin
            errors++; $display("FAIL r_add_addr: got %0d, expected 0", out_addr);
        end
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        check_word("i_addi", 32'h00500093);
        checks++;
        if (out_addr !== 8'd1) begin
            errors++; $display("FAIL i_addi_addr: got %0d, expected 1", out_addr);
        end
    endtask

    task automatic test_formats();
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        check_word("b_beq", 32'hFE000EE3);
        send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        check_word("j_jal", 32'h008000EF);
        send(3'd3, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        check_word("u_lui", 32'h12345137);
        // Edges of each legal range, mixed with junk in unused fields.
        send(3'd1, 7'h13, 5'd7, 5'd9, 5'd31, 3'd2, 7'h7F, 32'hFFFFF800);
        send(3'd1, 7'h13, 5'd7, 5'd9, 5'd31, 3'd2, 7'h7F, 32'd2047);
        send(3'd2, 7'h63, 5'd31, 5'd4, 5'd5, 3'd1, 7'h55, 32'd4094);
        send(3'd2, 7'h63, 5'd31, 5'd4, 5'd5, 3'd1, 7'h55, 32'hFFFFF000);
        send(3'd4, 7'h6F, 5'd5, 5'd3, 5'd3, 3'd7, 7'h11, 32'd1048574);
        send(3'd4, 7'h6F, 5'd5, 5'd3, 5'd3, 3'd7, 7'h11, 32'hFFF00000);
    endtask

    task automatic test_illegal();
        logic [7:0] a0;
        repeat (2) @(posedge clk);
        #1;
        a0 = m_addr;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(3'd3, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        send(3'd6, 7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd4 || s_err_count !== 2'd3) begin
            errors++;
            $display("FAIL illegal_drop: got v=%0b cnt=%0d scnt=%0d, expected v=0 cnt=4 scnt=3",
                     out_valid, err_count, s_err_count);
        end
        send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
        checks++;
        if (out_addr !== a0) begin
            errors++; $display("FAIL illegal_addr: got %0d, expected %0d", out_addr, a0);
        end
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        send(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF);
        send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send(3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] first;
        @(posedge clk); #1;
        out_ready = 1'b0;
        first = model_pack(3'd0, 7'h33, 5'd10, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(3'd0, 7'h33, 5'(10 + k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (out_instr !== first || req_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL backpressure_hold: got %08h rdy=%0b v=%0b, expected %08h rdy=0 v=1",
                                 out_instr, req_ready, out_valid, first);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 260; k++)
            send(3'd0, 7'h33, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), $urandom);
    endtask

    task automatic test_clear();
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        clear = 1'b1;
        req_fmt = 3'd0; req_op = 7'h33; req_rd = 5'd8; req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL clear_ready: got %0b, expected 1", req_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        req_valid = 1'b0;
        m_addr = 0;
        m_err = 0;
        checks++;
        if (out_valid !== 0 || err_count !== 0 || s_err_count !== 0 || err_pulse !== 0) begin
            errors++;
            $display("FAIL clear_state: got v=%0b cnt=%0d p=%0b, expected zeros", out_valid, err_count, err_pulse);
        end
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        checks++;
        if (out_addr !== 8'd0) begin
            errors++; $display("FAIL clear_addr: got %0d, expected 0", out_addr);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_fmt = 3'd0; req_op = 7'h33; req_rd = 5'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_held: got v=%0b, expected 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 0 || out_instr !== 0 || out_addr !== 0 || err_pulse !== 0 || err_count !== 0 || s_out_valid !== 0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b i=%08h a=%0d, expected zeros", out_valid, out_instr, out_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_addr = 0;
        m_err = 0;
        out_ready = 1'b1;
        send(3'd3, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        checks++;
        if (out_addr !== 8'd0 || out_instr !== 32'h12345137) begin
            errors++; $display("FAIL post_reset: got %08h@%0d, expected 12345137@0", out_instr, out_addr);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_formats();
        test_illegal();
        test_back_to_back();
        test_wrap();
        test_clear();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d words pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
